// File: rtl/uart_cmd_parser_pkg.sv
// Shared definitions for the UART command parser: opcode bytes, FSM states,
// operation kinds and the error codes raised while parsing a frame.
package uart_cmd_parser_pkg;

    localparam logic [7:0] OP_W_U = 8'h57;
    localparam logic [7:0] OP_W_L = 8'h77;
    localparam logic [7:0] OP_R_U = 8'h52;
    localparam logic [7:0] OP_R_L = 8'h72;

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        ISSUE,
        WAIT_RESP
    } state_e;

    typedef enum logic {
        OP_WR,
        OP_RD
    } op_e;

    typedef enum logic [2:0] {
        ERR_NONE,
        ERR_OPCODE,
        ERR_ADDR,
        ERR_TIMEOUT,
        ERR_OVERRUN
    } err_e;

    function automatic logic is_write_op(logic [7:0] b);
        return (b == OP_W_U) || (b == OP_W_L);
    endfunction

    function automatic logic is_read_op(logic [7:0] b);
        return (b == OP_R_U) || (b == OP_R_L);
    endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Byte stream from the UART receiver plus the strobe/address bus to register_file.
interface uart_cmd_parser_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       adress_status;
    logic       we;
    logic       re;
    logic [7:0] w_addr;
    logic [7:0] w_data;
    logic [7:0] r_addr;

    // slave: the parser; master: the receiver / register-file side driving it
    modport slave (
        input  rx_data, rx_valid, adress_status,
        output we, re, w_addr, w_data, r_addr
    );

    modport master (
        output rx_data, rx_valid, adress_status,
        input  we, re, w_addr, w_data, r_addr
    );
endinterface

// File: rtl/uart_cmd_parser_timeout_cnt.sv
// Inter-byte idle counter; expire flags the cycle after which the count
// reaches LIMIT-1, so the abort is seen LIMIT clocks after the last byte.
module uart_timeout_cnt #(
    parameter int LIMIT = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int            CW     = $clog2(LIMIT);
    localparam logic [CW-1:0] EXP_AT = CW'(LIMIT - 2);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = enable && (cnt == EXP_AT);

endmodule

// File: rtl/uart_cmd_parser.sv
// UART command parser: turns W/R byte frames into single-cycle register_file
// strobes, with address range check, inter-byte timeout and completion status.
module uart_cmd_parser
    import uart_cmd_parser_pkg::*;
#(
    parameter int NUM_REGS       = 64,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int RESP_LAT       = 2
) (
    input  logic             clk,
    input  logic             reset,
    uart_cmd_parser_if.slave bus,
    output logic             busy,
    output logic             cmd_done,
    output logic             cmd_ok,
    output logic             err_opcode,
    output logic             err_addr,
    output logic             err_timeout,
    output logic             err_overrun
);

    localparam int               LAT_W    = $clog2(RESP_LAT + 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RESP_LAT - 1);

    state_e           state, state_d;
    op_e              op, op_d;
    err_e             err_d;
    logic             sticky, sticky_d;
    logic [LAT_W-1:0] lat_cnt, lat_cnt_d;
    logic             we_d, re_d, done_d, ok_d;
    logic [7:0]       w_addr_d, w_data_d, r_addr_d;
    logic             tmo_run, tmo_expire;

    // Unsigned compare widened to 9 bits so NUM_REGS=256 accepts every address
    function automatic logic addr_in_range(logic [7:0] a);
        return {1'b0, a} < 9'(NUM_REGS);
    endfunction

    assign tmo_run = (state == GET_ADDR) || (state == GET_DATA);

    uart_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (bus.rx_valid || !tmo_run),
        .enable (tmo_run),
        .expire (tmo_expire)
    );

    always_comb begin
        state_d   = state;
        op_d      = op;
        err_d     = ERR_NONE;
        sticky_d  = sticky;
        lat_cnt_d = lat_cnt;
        we_d      = 1'b0;
        re_d      = 1'b0;
        done_d    = 1'b0;
        ok_d      = 1'b0;
        w_addr_d  = bus.w_addr;
        w_data_d  = bus.w_data;
        r_addr_d  = bus.r_addr;
        unique case (state)
            IDLE: begin
                if (bus.rx_valid) begin
                    if (is_write_op(bus.rx_data)) begin
                        op_d    = OP_WR;
                        state_d = GET_ADDR;
                    end else if (is_read_op(bus.rx_data)) begin
                        op_d    = OP_RD;
                        state_d = GET_ADDR;
                    end else begin
                        err_d = ERR_OPCODE;
                    end
                end
            end
            GET_ADDR: begin
                // A byte arriving on the expiry cycle still counts
                if (bus.rx_valid) begin
                    if (!addr_in_range(bus.rx_data)) begin
                        err_d   = ERR_ADDR;
                        state_d = IDLE;
                    end else if (op == OP_WR) begin
                        w_addr_d = bus.rx_data;
                        state_d  = GET_DATA;
                    end else begin
                        r_addr_d = bus.rx_data;
                        re_d     = 1'b1;
                        state_d  = ISSUE;
                    end
                end else if (tmo_expire) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = IDLE;
                end
            end
            GET_DATA: begin
                if (bus.rx_valid) begin
                    w_data_d = bus.rx_data;
                    we_d     = 1'b1;
                    state_d  = ISSUE;
                end else if (tmo_expire) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                sticky_d  = 1'b0;
                lat_cnt_d = '0;
                state_d   = WAIT_RESP;
                if (bus.rx_valid) err_d = ERR_OVERRUN;
            end
            WAIT_RESP: begin
                sticky_d  = sticky | bus.adress_status;
                lat_cnt_d = lat_cnt + 1'b1;
                if (bus.rx_valid) err_d = ERR_OVERRUN;
                if (lat_cnt == LAT_LAST) begin
                    done_d  = 1'b1;
                    ok_d    = sticky | bus.adress_status;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next-state decode, so strobes land in ISSUE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            op          <= OP_WR;
            sticky      <= 1'b0;
            lat_cnt     <= '0;
            busy        <= 1'b0;
            cmd_done    <= 1'b0;
            cmd_ok      <= 1'b0;
            err_opcode  <= 1'b0;
            err_addr    <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
            bus.we      <= 1'b0;
            bus.re      <= 1'b0;
            bus.w_addr  <= '0;
            bus.w_data  <= '0;
            bus.r_addr  <= '0;
        end else begin
            state       <= state_d;
            op          <= op_d;
            sticky      <= sticky_d;
            lat_cnt     <= lat_cnt_d;
            busy        <= (state_d != IDLE);
            cmd_done    <= done_d;
            cmd_ok      <= ok_d;
            err_opcode  <= (err_d == ERR_OPCODE);
            err_addr    <= (err_d == ERR_ADDR);
            err_timeout <= (err_d == ERR_TIMEOUT);
            err_overrun <= (err_d == ERR_OVERRUN);
            bus.we      <= we_d;
            bus.re      <= re_d;
            bus.w_addr  <= w_addr_d;
            bus.w_data  <= w_data_d;
            bus.r_addr  <= r_addr_d;
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: cycle-indexed event model of the
// frame rules compared every cycle, plus literal checks of the directed cases.
module tb_uart_cmd_parser;

    localparam int NUM_REGS = 64;
    localparam int TMO      = 10;
    localparam int RL       = 2;
    localparam int NC       = 1024;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic busy, cmd_done, cmd_ok, err_opcode, err_addr, err_timeout, err_overrun;

    uart_cmd_parser_if bus ();

    uart_cmd_parser #(
        .NUM_REGS       (NUM_REGS),
        .TIMEOUT_CYCLES (TMO),
        .RESP_LAT       (RL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .busy        (busy),
        .cmd_done    (cmd_done),
        .cmd_ok      (cmd_ok),
        .err_opcode  (err_opcode),
        .err_addr    (err_addr),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Model: expected events scheduled by cycle number
    bit         e_we [NC];
    bit         e_re [NC];
    bit         e_opc[NC];
    bit         e_adr[NC];
    bit         e_ovr[NC];
    logic [7:0] e_wa [NC];
    logic [7:0] e_wd [NC];
    logic [7:0] e_ra [NC];

    bit         m_open = 0, m_wr = 0, m_infl = 0, m_acc = 0;
    int         m_nb = 0, m_last = 0, m_f = 0;
    logic [7:0] m_waddr = '0;
    bit         x_tmo, x_done, x_ok, x_busy;
    int         t;

    // Observations used by the directed literal checks
    int         n_we = 0, n_re = 0, n_tmo = 0;
    int         last_we_cyc = -1, last_re_cyc = -1, last_done_cyc = -1;
    int         last_opc_cyc = -1, last_adr_cyc = -1, last_tmo_cyc = -1, last_ovr_cyc = -1;
    logic [7:0] lw_a = '0, lw_d = '0, lr_a = '0;
    logic       last_ok = 1'b0;

    always @(negedge clk) begin
        t = cyc;
        if (!reset) begin
            check("rst_ctrl", {23'd0, busy, cmd_done, cmd_ok, err_opcode, err_addr,
                               err_timeout, err_overrun, bus.we, bus.re}, 32'd0);
            check("rst_regs", {8'd0, bus.w_addr, bus.w_data, bus.r_addr}, 32'd0);
            m_open = 0;
            m_infl = 0;
            for (int k = t; k < t + 8 && k < NC; k++) begin
                e_we[k] = 0; e_re[k] = 0; e_opc[k] = 0; e_adr[k] = 0; e_ovr[k] = 0;
            end
        end else begin
            x_tmo  = 0;
            x_done = 0;
            x_ok   = 0;
            if (m_open && t == m_last + TMO) begin
                x_tmo  = 1;
                m_open = 0;
            end
            if (m_infl && t == m_f + 2 + RL) begin
                x_done = 1;
                x_ok   = m_acc;
                m_infl = 0;
            end
            x_busy = m_open || m_infl;

            check("busy",        {31'd0, busy},        {31'd0, x_busy});
            check("we",          {31'd0, bus.we},      {31'd0, e_we[t]});
            check("re",          {31'd0, bus.re},      {31'd0, e_re[t]});
            check("cmd_done",    {31'd0, cmd_done},    {31'd0, x_done});
            check("cmd_ok",      {31'd0, cmd_ok},      {31'd0, x_ok});
            check("err_opcode",  {31'd0, err_opcode},  {31'd0, e_opc[t]});
            check("err_addr",    {31'd0, err_addr},    {31'd0, e_adr[t]});
            check("err_timeout", {31'd0, err_timeout}, {31'd0, x_tmo});
            check("err_overrun", {31'd0, err_overrun}, {31'd0, e_ovr[t]});
            if (e_we[t]) check("w_addr_data", {16'd0, bus.w_addr, bus.w_data}, {16'd0, e_wa[t], e_wd[t]});
            if (e_re[t]) check("r_addr", {24'd0, bus.r_addr}, {24'd0, e_ra[t]});

            if (m_infl && t >= m_f + 2) m_acc = m_acc | bus.adress_status;

            if (bus.rx_valid && t + 1 < NC) begin
                if (m_infl) begin
                    e_ovr[t+1] = 1;
                end else if (!m_open) begin
                    if (bus.rx_data == 8'h57 || bus.rx_data == 8'h77 ||
                        bus.rx_data == 8'h52 || bus.rx_data == 8'h72) begin
                        m_open = 1;
                        m_wr   = (bus.rx_data == 8'h57 || bus.rx_data == 8'h77);
                        m_nb   = 1;
                        m_last = t;
                    end else begin
                        e_opc[t+1] = 1;
                    end
                end else if (m_nb == 1) begin
                    if (int'(bus.rx_data) >= NUM_REGS) begin
                        e_adr[t+1] = 1;
                        m_open     = 0;
                    end else if (m_wr) begin
                        m_waddr = bus.rx_data;
                        m_nb    = 2;
                        m_last  = t;
                    end else begin
                        e_re[t+1] = 1;
                        e_ra[t+1] = bus.rx_data;
                        m_open = 0; m_infl = 1; m_f = t; m_acc = 0;
                    end
                end else begin
                    e_we[t+1] = 1;
                    e_wa[t+1] = m_waddr;
                    e_wd[t+1] = bus.rx_data;
                    m_open = 0; m_infl = 1; m_f = t; m_acc = 0;
                end
            end
        end

        if (bus.we)      begin n_we++; last_we_cyc = t; lw_a = bus.w_addr; lw_d = bus.w_data; end
        if (bus.re)      begin n_re++; last_re_cyc = t; lr_a = bus.r_addr; end
        if (cmd_done)    begin last_done_cyc = t; last_ok = cmd_ok; end
        if (err_opcode)  last_opc_cyc = t;
        if (err_addr)    last_adr_cyc = t;
        if (err_timeout) begin n_tmo++; last_tmo_cyc = t; end
        if (err_overrun) last_ovr_cyc = t;
    end

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    int b, nwe_snap;

    initial begin
        bus.rx_data       = '0;
        bus.rx_valid      = 1'b0;
        bus.adress_status = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        idle(2);

        // Write 57 05 A3 with status high
        bus.adress_status = 1'b1;
        send_byte(8'h57); send_byte(8'h05);
        b = cyc; send_byte(8'hA3);
        idle(6);
        bus.adress_status = 1'b0;
        check("wr_strobe_cyc", last_we_cyc, b + 1);
        check("wr_addr", {24'd0, lw_a}, 32'h05);
        check("wr_data", {24'd0, lw_d}, 32'hA3);
        check("wr_done_cyc", last_done_cyc, b + 4);
        check("wr_ok", {31'd0, last_ok}, 32'd1);
        check("wr_no_re", n_re, 0);

        // Read 72 3F with status low
        send_byte(8'h72);
        b = cyc; send_byte(8'h3F);
        idle(6);
        check("rd_strobe_cyc", last_re_cyc, b + 1);
        check("rd_addr", {24'd0, lr_a}, 32'h3F);
        check("rd_done_cyc", last_done_cyc, b + 4);
        check("rd_ok", {31'd0, last_ok}, 32'd0);
        check("rd_no_we", n_we, 1);

        // Address 0x40 out of range
        send_byte(8'h52);
        b = cyc; send_byte(8'h40);
        idle(2);
        check("range_err_cyc", last_adr_cyc, b + 1);
        check("range_no_re", n_re, 1);

        // Highest legal address, status pulsed only in the last sample cycle
        send_byte(8'h77); send_byte(8'h3F);
        b = cyc; send_byte(8'h5A);
        idle(2);
        bus.adress_status = 1'b1;
        idle(1);
        bus.adress_status = 1'b0;
        idle(3);
        check("edge_wr_addr", {24'd0, lw_a}, 32'h3F);
        check("edge_ok", {31'd0, last_ok}, 32'd1);
        check("edge_done_cyc", last_done_cyc, b + 4);

        // Unknown opcode
        b = cyc; send_byte(8'h41);
        idle(2);
        check("opcode_err_cyc", last_opc_cyc, b + 1);

        // Timeout after 57 01, then a normal read
        send_byte(8'h57);
        b = cyc; send_byte(8'h01);
        idle(12);
        check("tmo_cyc", last_tmo_cyc, b + 10);
        send_byte(8'h52);
        b = cyc; send_byte(8'h01);
        idle(5);
        check("post_tmo_re_cyc", last_re_cyc, b + 1);
        check("post_tmo_r_addr", {24'd0, lr_a}, 32'h01);

        // Byte on the expiry cycle wins over the timeout
        send_byte(8'h57); send_byte(8'h02);
        idle(8);
        b = cyc; send_byte(8'hC3);
        idle(6);
        check("late_byte_we_cyc", last_we_cyc, b + 1);
        check("late_byte_data", {24'd0, lw_d}, 32'hC3);
        check("late_byte_no_tmo", n_tmo, 1);

        // Overrun during WAIT_RESP
        bus.adress_status = 1'b1;
        send_byte(8'h57); send_byte(8'h10);
        b = cyc; send_byte(8'h20);
        idle(1);
        send_byte(8'h99);
        idle(5);
        bus.adress_status = 1'b0;
        check("ovr_cyc", last_ovr_cyc, b + 3);
        check("ovr_done_cyc", last_done_cyc, b + 4);
        check("ovr_ok", {31'd0, last_ok}, 32'd1);
        check("ovr_wdata", {24'd0, lw_d}, 32'h20);

        // Asynchronous reset while waiting for the data byte
        send_byte(8'h57); send_byte(8'h11);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        nwe_snap = n_we;
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_ctrl", {25'd0, busy, cmd_done, cmd_ok, err_opcode, err_addr,
                               err_timeout, err_overrun}, 32'd0);
        check("mid_rst_regs", {8'd0, bus.w_addr, bus.w_data, bus.r_addr}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        b = cyc; send_byte(8'h22);
        idle(5);
        check("mid_rst_no_we", n_we, nwe_snap);
        check("mid_rst_opc_cyc", last_opc_cyc, b + 1);

        idle(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
